serial_rx_ctrl: RTL and testbench

//  Receive-side controller for an asynchronous serial byte link (UART-style: 1 start, DATA_BITS, 1 stop).

---
 rtl/serial_rx_pkg.sv | 14 +
 rtl/flex_counter.sv | 26 ++
 rtl/serial_rx_ctrl.sv | 125 ++++++++++++
 tb/tb_serial_rx_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_rx_pkg.sv
// rtl/serial_rx_pkg.sv - shared state encoding and default frame geometry for the serial receiver
package serial_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int DEF_CLKS_PER_BIT = 10;
    localparam int DEF_DATA_BITS    = 8;

endpackage

// File: rtl/flex_counter.sv
// rtl/flex_counter.sv - clearable up-counter running 0..rollover_val-1 with terminal-count flag
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    assign rollover_flag = (count_out == rollover_val - 1'b1);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out <= '0;
        end else if (clear) begin
            count_out <= '0;
        end else if (count_enable) begin
            count_out <= rollover_flag ? '0 : count_out + 1'b1;
        end
    end

endmodule

// File: rtl/serial_rx_ctrl.sv
// rtl/serial_rx_ctrl.sv - UART-style receive controller: sync, start detect, bit sampling, byte delivery
module serial_rx_ctrl
    import serial_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int BP_BITS      = $clog2(CLKS_PER_BIT + 1)
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 serial_in,
    input  logic                 data_read,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 framing_error,
    output logic                 overrun_error
);

    localparam int BC_BITS = $clog2(DATA_BITS + 1);
    localparam logic [BP_BITS-1:0] BP_ROLL = BP_BITS'(CLKS_PER_BIT);
    localparam logic [BP_BITS-1:0] BP_MID  = BP_BITS'(CLKS_PER_BIT / 2);
    localparam logic [BC_BITS-1:0] BC_ROLL = BC_BITS'(DATA_BITS);

    rx_state_t            state;
    logic                 sync_1, sync_2, line_prev;
    logic [1:0]           sync_fill;
    logic                 armed;
    logic [DATA_BITS-1:0] shift_reg;

    logic [BP_BITS-1:0]   bp_count;
    logic                 bp_rollover_unused;
    logic [BC_BITS-1:0]   bc_count_unused;
    logic                 bc_rollover;
    logic                 counters_clear, sample, start_edge;

    assign counters_clear = (state == IDLE);
    assign sample         = (state != IDLE) && (bp_count == BP_MID);
    assign start_edge     = armed && line_prev && !sync_2;

    flex_counter #(.NUM_CNT_BITS(BP_BITS)) u_bit_period (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (counters_clear),
        .count_enable  (state != IDLE),
        .rollover_val  (BP_ROLL),
        .count_out     (bp_count),
        .rollover_flag (bp_rollover_unused)
    );

    flex_counter #(.NUM_CNT_BITS(BC_BITS)) u_bit_count (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (counters_clear),
        .count_enable  (sample && (state == DATA)),
        .rollover_val  (BC_ROLL),
        .count_out     (bc_count_unused),
        .rollover_flag (bc_rollover)
    );

    // Synchronizer flops reset high, so a line held low out of reset would look like a fall;
    // armed only rises once a genuinely sampled high has reached sync_2.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_1        <= 1'b1;
            sync_2        <= 1'b1;
            line_prev     <= 1'b1;
            sync_fill     <= 2'b00;
            armed         <= 1'b0;
            state         <= IDLE;
            shift_reg     <= '0;
            rx_data       <= '0;
            data_ready    <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            sync_1    <= serial_in;
            sync_2    <= sync_1;
            line_prev <= sync_2;
            sync_fill <= {sync_fill[0], 1'b1};
            armed     <= armed | (sync_fill[1] & sync_2);

            if (data_read) begin
                data_ready    <= 1'b0;
                overrun_error <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start_edge) state <= START;
                end
                START: begin
                    if (sample) begin
                        if (sync_2) begin
                            state <= IDLE;
                        end else begin
                            state         <= DATA;
                            framing_error <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (sample) begin
                        shift_reg <= {sync_2, shift_reg[DATA_BITS-1:1]};
                        if (bc_rollover) state <= STOP;
                    end
                end
                STOP: begin
                    if (sample) begin
                        state <= IDLE;
                        // A load issued alongside data_read overrides the clear above.
                        if (sync_2) begin
                            rx_data    <= shift_reg;
                            data_ready <= 1'b1;
                            if (data_ready && !data_read) overrun_error <= 1'b1;
                        end else begin
                            framing_error <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_rx_ctrl.sv
// tb/tb_serial_rx_ctrl.sv - scoreboard bench for serial_rx_ctrl at 10 clks/bit, 8 data bits
module tb_serial_rx_ctrl;

    localparam int CLKS = 10;
    localparam int DB   = 8;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          serial_in;
    logic          data_read;
    logic [DB-1:0] rx_data;
    logic          data_ready;
    logic          framing_error;
    logic          overrun_error;

    int            n_vec = 0;
    int            n_err = 0;
    logic [DB-1:0] sb[$];
    logic [DB-1:0] exp_word;

    serial_rx_ctrl #(.CLKS_PER_BIT(CLKS), .DATA_BITS(DB)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .serial_in     (serial_in),
        .data_read     (data_read),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .framing_error (framing_error),
        .overrun_error (overrun_error)
    );

    always #5 clk = ~clk;

    // Called and returns one time unit after a rising edge.
    task automatic send_frame(input logic [DB-1:0] data, input logic stop_bit);
        logic [DB+1:0] bits;
        bits = {stop_bit, data, 1'b0};
        if (stop_bit) sb.push_back(data);
        for (int i = 0; i < DB + 2; i++) begin
            serial_in = bits[i];
            repeat (CLKS) @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_read();
        data_read = 1'b1;
        @(posedge clk);
        #1;
        data_read = 1'b0;
    endtask

    task automatic pop_expected();
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_empty got size 0 want >0");
            exp_word = 'x;
        end else begin
            exp_word = sb.pop_front();
        end
    endtask

    task automatic test_reset();
        n_rst     = 1'b0;
        serial_in = 1'b0;
        data_read = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({rx_data, data_ready, framing_error, overrun_error} !== 11'h000) begin
            n_err++;
            $display("FAIL reset_state got %h want 000", {rx_data, data_ready, framing_error, overrun_error});
        end
        n_rst = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        n_vec++;
        if ({rx_data, data_ready, framing_error, overrun_error} !== 11'h000) begin
            n_err++;
            $display("FAIL held_low got %h want 000", {rx_data, data_ready, framing_error, overrun_error});
        end
        serial_in = 1'b1;
        repeat (120) @(posedge clk);
        #1;
        n_vec++;
        if ({rx_data, data_ready, framing_error, overrun_error} !== 11'h000) begin
            n_err++;
            $display("FAIL no_phantom_frame got %h want 000", {rx_data, data_ready, framing_error, overrun_error});
        end
    endtask

    task automatic test_good_frame();
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (98) @(posedge clk);
                #1;
                n_vec++;
                if (data_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL latency_early got %b want 0", data_ready);
                end
                @(posedge clk);
                #1;
                n_vec++;
                if (data_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL latency_rise got %b want 1", data_ready);
                end
            end
        join
        pop_expected();
        n_vec++;
        if ({rx_data, data_ready, framing_error, overrun_error} !== {exp_word, 3'b100}) begin
            n_err++;
            $display("FAIL good_frame got %h want %h", {rx_data, data_ready, framing_error, overrun_error}, {exp_word, 3'b100});
        end
    endtask

    task automatic test_glitch();
        pulse_read();
        n_vec++;
        if ({data_ready, overrun_error} !== 2'b00) begin
            n_err++;
            $display("FAIL read_clears got %b want 00", {data_ready, overrun_error});
        end
        serial_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        serial_in = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        n_vec++;
        if ({rx_data, data_ready, framing_error, overrun_error} !== {8'hA5, 3'b000}) begin
            n_err++;
            $display("FAIL glitch got %h want %h", {rx_data, data_ready, framing_error, overrun_error}, {8'hA5, 3'b000});
        end
    endtask

    task automatic test_framing();
        send_frame(8'h5A, 1'b0);
        n_vec++;
        if ({rx_data, data_ready, framing_error, overrun_error} !== {8'hA5, 3'b010}) begin
            n_err++;
            $display("FAIL framing_set got %h want %h", {rx_data, data_ready, framing_error, overrun_error}, {8'hA5, 3'b010});
        end
        serial_in = 1'b1;
        repeat (CLKS) @(posedge clk);
        #1;
        fork
            send_frame(8'h11, 1'b1);
            begin
                repeat (8) @(posedge clk);
                #1;
                n_vec++;
                if (framing_error !== 1'b1) begin
                    n_err++;
                    $display("FAIL framing_sticky got %b want 1", framing_error);
                end
                @(posedge clk);
                #1;
                n_vec++;
                if (framing_error !== 1'b0) begin
                    n_err++;
                    $display("FAIL framing_cleared got %b want 0", framing_error);
                end
            end
        join
        pop_expected();
        n_vec++;
        if ({rx_data, data_ready, framing_error, overrun_error} !== {exp_word, 3'b100}) begin
            n_err++;
            $display("FAIL after_framing got %h want %h", {rx_data, data_ready, framing_error, overrun_error}, {exp_word, 3'b100});
        end
        pulse_read();
    endtask

    task automatic test_overrun();
        send_frame(8'h01, 1'b1);
        pop_expected();
        n_vec++;
        if ({rx_data, data_ready, framing_error, overrun_error} !== {exp_word, 3'b100}) begin
            n_err++;
            $display("FAIL overrun_first got %h want %h", {rx_data, data_ready, framing_error, overrun_error}, {exp_word, 3'b100});
        end
        send_frame(8'h02, 1'b1);
        pop_expected();
        n_vec++;
        if ({rx_data, data_ready, framing_error, overrun_error} !== {exp_word, 3'b101}) begin
            n_err++;
            $display("FAIL overrun_second got %h want %h", {rx_data, data_ready, framing_error, overrun_error}, {exp_word, 3'b101});
        end
        pulse_read();
        n_vec++;
        if ({rx_data, data_ready, framing_error, overrun_error} !== {8'h02, 3'b000}) begin
            n_err++;
            $display("FAIL overrun_read got %h want %h", {rx_data, data_ready, framing_error, overrun_error}, {8'h02, 3'b000});
        end
    endtask

    task automatic test_back_to_back_read();
        send_frame(8'h33, 1'b1);
        pop_expected();
        n_vec++;
        if ({rx_data, data_ready, framing_error, overrun_error} !== {exp_word, 3'b100}) begin
            n_err++;
            $display("FAIL b2b_first got %h want %h", {rx_data, data_ready, framing_error, overrun_error}, {exp_word, 3'b100});
        end
        fork
            send_frame(8'h44, 1'b1);
            begin
                repeat (98) @(posedge clk);
                #1;
                data_read = 1'b1;
                @(posedge clk);
                #1;
                data_read = 1'b0;
            end
        join
        pop_expected();
        n_vec++;
        if ({rx_data, data_ready, framing_error, overrun_error} !== {exp_word, 3'b100}) begin
            n_err++;
            $display("FAIL load_with_read got %h want %h", {rx_data, data_ready, framing_error, overrun_error}, {exp_word, 3'b100});
        end
    endtask

    task automatic test_reset_mid_frame();
        serial_in = 1'b0;
        repeat (CLKS) @(posedge clk);
        #1;
        serial_in = 1'b1;
        repeat (4 * CLKS + 5) @(posedge clk);
        #1;
        n_rst = 1'b0;
        #1;
        n_vec++;
        if ({rx_data, data_ready, framing_error, overrun_error} !== 11'h000) begin
            n_err++;
            $display("FAIL midframe_reset got %h want 000", {rx_data, data_ready, framing_error, overrun_error});
        end
        repeat (3) @(posedge clk);
        #1;
        n_rst = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        n_vec++;
        if ({rx_data, data_ready, framing_error, overrun_error} !== 11'h000) begin
            n_err++;
            $display("FAIL midframe_idle got %h want 000", {rx_data, data_ready, framing_error, overrun_error});
        end
        send_frame(8'h3C, 1'b1);
        pop_expected();
        n_vec++;
        if ({rx_data, data_ready, framing_error, overrun_error} !== {exp_word, 3'b100}) begin
            n_err++;
            $display("FAIL post_reset_frame got %h want %h", {rx_data, data_ready, framing_error, overrun_error}, {exp_word, 3'b100});
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_glitch();
        test_framing();
        test_overrun();
        test_back_to_back_read();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
